// File: rtl/usb_wb_arbiter_if.sv
// usb_wb_arbiter_if: bus bundle between two Wishbone requesters, the arbiter and the USB core.
// Ports: m0_*/m1_* requester side, s_* USB-core side, timeout_flag_o; slave = arbiter view.
interface usb_wb_arbiter_if;
  logic [7:0] m0_address_i;
  logic [7:0] m1_address_i;
  logic [7:0] m0_data_i;
  logic [7:0] m1_data_i;
  logic       m0_we_i;
  logic       m1_we_i;
  logic       m0_strobe_i;
  logic       m1_strobe_i;
  logic [7:0] m0_data_o;
  logic [7:0] m1_data_o;
  logic       m0_ack_o;
  logic       m1_ack_o;
  logic       m0_err_o;
  logic       m1_err_o;
  logic [7:0] s_address_o;
  logic [7:0] s_data_o;
  logic       s_we_o;
  logic       s_strobe_o;
  logic [7:0] s_data_i;
  logic       s_ack_i;
  logic       timeout_flag_o;

  modport slave (
    input  m0_address_i, m1_address_i,
    input  m0_data_i, m1_data_i,
    input  m0_we_i, m1_we_i,
    input  m0_strobe_i, m1_strobe_i,
    output m0_data_o, m1_data_o,
    output m0_ack_o, m1_ack_o,
    output m0_err_o, m1_err_o,
    output s_address_o, s_data_o,
    output s_we_o, s_strobe_o,
    input  s_data_i, s_ack_i,
    output timeout_flag_o
  );

  modport master (
    output m0_address_i, m1_address_i,
    output m0_data_i, m1_data_i,
    output m0_we_i, m1_we_i,
    output m0_strobe_i, m1_strobe_i,
    input  m0_data_o, m1_data_o,
    input  m0_ack_o, m1_ack_o,
    input  m0_err_o, m1_err_o,
    input  s_address_o, s_data_o,
    input  s_we_o, s_strobe_o,
    output s_data_i, s_ack_i,
    input  timeout_flag_o
  );
endinterface

// File: rtl/usb_wb_arbiter.sv
// usb_wb_arbiter: round-robin 2-master arbiter with timeout watchdog for the USB register port.
// Ports: clk_i, rst_i (async, active high), bus (usb_wb_arbiter_if.slave); all outputs registered.
module usb_wb_arbiter #(
  parameter int TIMEOUT   = 255,
  parameter int CNT_WIDTH = 16
) (
  input logic             clk_i,
  input logic             rst_i,
  usb_wb_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CntMax =
    CNT_WIDTH'(TIMEOUT - 1);

  state_t               state;
  logic                 grant;
  logic                 last;
  logic                 pick;
  logic [CNT_WIDTH-1:0] cnt;
  logic [7:0]           sAddr;
  logic [7:0]           sData;
  logic                 sWe;
  logic                 sStb;
  logic [7:0]           m0Data;
  logic [7:0]           m1Data;
  logic                 m0Ack;
  logic                 m1Ack;
  logic                 m0Err;
  logic                 m1Err;
  logic                 toFlag;

  // Under contention the master not served last wins.
  always_comb begin
    pick = bus.m1_strobe_i;
    if (bus.m0_strobe_i && bus.m1_strobe_i)
      pick = ~last;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state  <= IDLE;
      grant  <= 1'b0;
      last   <= 1'b1;
      cnt    <= '0;
      sAddr  <= 8'h00;
      sData  <= 8'h00;
      sWe    <= 1'b0;
      sStb   <= 1'b0;
      m0Data <= 8'h00;
      m1Data <= 8'h00;
      m0Ack  <= 1'b0;
      m1Ack  <= 1'b0;
      m0Err  <= 1'b0;
      m1Err  <= 1'b0;
      toFlag <= 1'b0;
    end else begin
      m0Ack <= 1'b0;
      m1Ack <= 1'b0;
      m0Err <= 1'b0;
      m1Err <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.m0_strobe_i || bus.m1_strobe_i) begin
            grant <= pick;
            last  <= pick;
            sAddr <= pick ? bus.m1_address_i
                          : bus.m0_address_i;
            sData <= pick ? bus.m1_data_i
                          : bus.m0_data_i;
            sWe   <= pick ? bus.m1_we_i
                          : bus.m0_we_i;
            sStb  <= 1'b1;
            cnt   <= '0;
            state <= BUSY;
          end
        end
        BUSY: begin
          // Ack takes priority over a coincident timeout.
          if (bus.s_ack_i) begin
            sStb  <= 1'b0;
            state <= DONE;
            if (grant) begin
              m1Data <= bus.s_data_i;
              m1Ack  <= 1'b1;
            end else begin
              m0Data <= bus.s_data_i;
              m0Ack  <= 1'b1;
            end
          end else if (cnt == CntMax) begin
            sStb   <= 1'b0;
            toFlag <= 1'b1;
            state  <= DONE;
            if (grant) begin
              m1Data <= 8'hFF;
              m1Err  <= 1'b1;
            end else begin
              m0Data <= 8'hFF;
              m0Err  <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        // Requester still holds strobe here;
        // skip a grant so it is not re-served.
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.s_address_o    = sAddr;
  assign bus.s_data_o       = sData;
  assign bus.s_we_o         = sWe;
  assign bus.s_strobe_o     = sStb;
  assign bus.m0_data_o      = m0Data;
  assign bus.m1_data_o      = m1Data;
  assign bus.m0_ack_o       = m0Ack;
  assign bus.m1_ack_o       = m1Ack;
  assign bus.m0_err_o       = m0Err;
  assign bus.m1_err_o       = m1Err;
  assign bus.timeout_flag_o = toFlag;

endmodule

// File: tb/tb_usb_wb_arbiter.sv
// tb_usb_wb_arbiter: directed plus randomized bench for usb_wb_arbiter.
// Ports: none; drives the interface as both requesters and as the USB-core slave.
module tb_usb_wb_arbiter;

  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  usb_wb_arbiter_if bus ();

  usb_wb_arbiter #(
    .TIMEOUT  (TO),
    .CNT_WIDTH(16)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  int tests = 0;
  int fails = 0;

  logic [7:0] reqA[2];
  logic [7:0] reqD[2];
  logic       reqW[2];
  bit         pend[2];
  bit         last = 1'b1;
  bit         flag = 1'b0;
  logic [7:0] dat[2];

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic drive(int m);
    if (m == 0) begin
      bus.m0_address_i = reqA[0];
      bus.m0_data_i    = reqD[0];
      bus.m0_we_i      = reqW[0];
      bus.m0_strobe_i  = pend[0];
    end else begin
      bus.m1_address_i = reqA[1];
      bus.m1_data_i    = reqD[1];
      bus.m1_we_i      = reqW[1];
      bus.m1_strobe_i  = pend[1];
    end
  endtask

  task automatic raise(int m, logic [7:0] a,
                       logic [7:0] d, logic w);
    reqA[m] = a;
    reqD[m] = d;
    reqW[m] = w;
    pend[m] = 1'b1;
    drive(m);
  endtask

  task automatic newReq(int m);
    raise(m, 8'($urandom), 8'($urandom),
          1'($urandom_range(0, 1)));
  endtask

  function automatic logic ackOf(int m);
    return (m == 0) ? bus.m0_ack_o : bus.m1_ack_o;
  endfunction

  function automatic logic errOf(int m);
    return (m == 0) ? bus.m0_err_o : bus.m1_err_o;
  endfunction

  function automatic logic [7:0] datOf(int m);
    return (m == 0) ? bus.m0_data_o : bus.m1_data_o;
  endfunction

  // Round-robin rule: contention goes to the
  // master not served last; otherwise the sole one.
  function automatic int nextGrant();
    if (pend[0] && pend[1]) return last ? 0 : 1;
    return pend[1] ? 1 : 0;
  endfunction

  task automatic checkReset(string tag);
    chk({tag, ".sOut"},
        {bus.s_address_o, bus.s_data_o,
         bus.s_we_o, bus.s_strobe_o}, 0);
    chk({tag, ".mPulse"},
        {bus.m0_ack_o, bus.m0_err_o,
         bus.m1_ack_o, bus.m1_err_o}, 0);
    chk({tag, ".mData"},
        {bus.m0_data_o, bus.m1_data_o}, 0);
    chk({tag, ".flag"}, bus.timeout_flag_o, 0);
  endtask

  // One transfer: w is the BUSY-cycle index at which
  // the slave acks; w >= TO means it never acks.
  task automatic serve(int w, logic [7:0] rd,
                       bit reReq);
    int  g;
    int  n;
    int  k;
    bit  tmo;
    g    = nextGrant();
    last = g[0];
    tmo  = (w >= TO);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.s_strobe_o && n < 20);
    chk("grantLatency", n, 1);
    chk("sReq",
        {bus.s_address_o, bus.s_data_o, bus.s_we_o},
        {reqA[g], reqD[g], reqW[g]});
    k = 0;
    while (bus.s_strobe_o && k < TO + 4) begin
      bus.s_ack_i  = (k == w);
      bus.s_data_i = (k == w) ? rd : 8'($urandom);
      @(negedge clk);
      k++;
      if (bus.s_strobe_o)
        chk("sStable",
            {bus.s_address_o, bus.s_data_o,
             bus.s_we_o},
            {reqA[g], reqD[g], reqW[g]});
    end
    chk("strobeLen", k, tmo ? TO : w + 1);
    if (tmo) begin
      dat[g] = 8'hFF;
      flag   = 1'b1;
    end else begin
      dat[g] = rd;
    end
    chk("ack", ackOf(g), !tmo);
    chk("err", errOf(g), tmo);
    chk("otherQuiet",
        {ackOf(1 - g), errOf(1 - g)}, 0);
    chk("dataG", datOf(g), dat[g]);
    chk("dataOther", datOf(1 - g), dat[1 - g]);
    chk("flag", bus.timeout_flag_o, flag);
    pend[g] = 1'b0;
    drive(g);
    // Stray acks outside BUSY must be ignored.
    bus.s_ack_i  = 1'($urandom_range(0, 1));
    bus.s_data_i = 8'($urandom);
    @(negedge clk);
    chk("pulseEnd",
        {bus.m0_ack_o, bus.m0_err_o, bus.m1_ack_o,
         bus.m1_err_o, bus.s_strobe_o}, 0);
    chk("dataHold",
        {bus.m0_data_o, bus.m1_data_o},
        {dat[0], dat[1]});
    bus.s_ack_i = 1'($urandom_range(0, 1));
    if (reReq)
      for (int m = 0; m < 2; m++)
        if (!pend[m] && $urandom_range(0, 1) == 1)
          newReq(m);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "bench did not finish");
  end

  initial begin
    int sel;
    dat[0] = 8'h00;
    dat[1] = 8'h00;
    for (int m = 0; m < 2; m++) begin
      reqA[m] = 8'h00;
      reqD[m] = 8'h00;
      reqW[m] = 1'b0;
      pend[m] = 1'b0;
      drive(m);
    end
    bus.s_ack_i  = 1'b0;
    bus.s_data_i = 8'h00;
    repeat (2) @(negedge clk);
    checkReset("reset");
    rst = 1'b0;

    raise(0, 8'h10, 8'hA5, 1'b1);
    serve(1, 8'h5A, 1'b0);

    raise(1, 8'h20, 8'h00, 1'b0);
    serve(4, 8'h3C, 1'b0);

    for (int i = 0; i < 6; i++) begin
      if (!pend[0]) raise(0, 8'h40 + 8'(i), 8'(i), 1'b1);
      if (!pend[1]) raise(1, 8'h80 + 8'(i), 8'(i), 1'b0);
      serve(i % 3, 8'($urandom), 1'b0);
    end
    serve(0, 8'h77, 1'b0);

    raise(0, 8'h31, 8'h13, 1'b0);
    serve(TO - 1, 8'hC3, 1'b0);

    raise(0, 8'h32, 8'h23, 1'b1);
    serve(TO + 1, 8'h00, 1'b0);

    raise(1, 8'h33, 8'h33, 1'b0);
    serve(2, 8'h96, 1'b0);

    raise(0, 8'h34, 8'h44, 1'b1);
    @(negedge clk);
    chk("preReset.strobe", bus.s_strobe_o, 1);
    #2 rst = 1'b1;
    #1 checkReset("asyncReset");
    pend[0] = 1'b0;
    drive(0);
    last   = 1'b1;
    flag   = 1'b0;
    dat[0] = 8'h00;
    dat[1] = 8'h00;
    @(negedge clk);
    rst = 1'b0;
    raise(1, 8'h35, 8'h55, 1'b1);
    serve(0, 8'hE1, 1'b0);

    for (int i = 0; i < 60; i++) begin
      if (!pend[0] && !pend[1]) begin
        sel = $urandom_range(1, 3);
        if (sel[0]) newReq(0);
        if (sel[1]) newReq(1);
      end
      serve($urandom_range(0, 9), 8'($urandom), 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

endmodule
